food_position_generator: RTL and testbench

- Parametrised successor to the free-running grid position counter.
- A 16-bit LFSR is drawn on request and mapped to a cell index on a configurable grid. Out-of-grid or occupied candidates are rejected and redrawn.
- Returns pixel coordinates of a free cell through a req/valid handshake.
- Sits between game control (requests a new food/target position) and the VGA-domain occupancy lookup (snake body map). Everything runs on VGA_clk.

---
 rtl/food_position_generator.sv | 169 ++++++++++++++++
 tb/tb_food_position_generator.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_position_generator.sv
// Food/target position generator.
// Draws a 16-bit Fibonacci LFSR on request, maps it to a grid cell, rejects
// out-of-grid or occupied cells and returns the pixel coordinates of a free
// cell through a req/valid handshake. Gives up with a fail pulse after
// MAX_TRIES draws.
// Optional build macro: FOOD_GEN_SEED_LOAD_EN adds seed_ld/seed for runtime
// reseeding of the LFSR.
module food_position_generator #(
    parameter int unsigned X_CELLS   = 62,
    parameter int unsigned Y_CELLS   = 46,
    parameter int unsigned CELL_SIZE = 10,
    parameter int unsigned ORIGIN_X  = 10,
    parameter int unsigned ORIGIN_Y  = 10,
    parameter int unsigned MAX_TRIES = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        VGA_clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        blocked,
`ifdef FOOD_GEN_SEED_LOAD_EN
    input  logic        seed_ld,
    input  logic [15:0] seed,
`endif
    output logic [9:0]  cand_x,
    output logic [8:0]  cand_y,
    output logic [9:0]  rand_x,
    output logic [8:0]  rand_y,
    output logic        valid,
    output logic        fail,
    output logic        busy
);

    // Index field widths; a single-cell axis still needs one bit of index.
    localparam int unsigned XW = (X_CELLS > 1) ? $clog2(X_CELLS) : 1;
    localparam int unsigned YW = (Y_CELLS > 1) ? $clog2(Y_CELLS) : 1;

    localparam logic [7:0] MaxTries = 8'(MAX_TRIES);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StDraw  = 3'd1;
    localparam logic [2:0] StCheck = 3'd2;
    localparam logic [2:0] StDone  = 3'd3;
    localparam logic [2:0] StFail  = 3'd4;

    logic [15:0]   lfsr_q, lfsr_d;
    logic          lfsr_fb;
    logic [2:0]    state_q, state_d;
    logic [7:0]    tries_q, tries_d;
    logic [7:0]    tries_inc;
    logic [9:0]    cand_x_q, cand_x_d;
    logic [8:0]    cand_y_q, cand_y_d;
    logic [9:0]    rand_x_q, rand_x_d;
    logic [8:0]    rand_y_q, rand_y_d;
    logic [XW-1:0] xi;
    logic [YW-1:0] yi;
    logic          in_range;
    logic [9:0]    px;
    logic [8:0]    py;

    // LFSR next value: free-running advance, zero lock-up escape, optional load.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        if (lfsr_q == 16'h0000) begin
            lfsr_d = 16'h0001;
        end else begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
`ifdef FOOD_GEN_SEED_LOAD_EN
        if (seed_ld) begin
            lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
        end
`endif
    end

    // LFSR register.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Candidate cell from disjoint LFSR fields and its pixel coordinates.
    always_comb begin
        xi       = lfsr_q[XW-1:0];
        yi       = lfsr_q[XW+YW-1:XW];
        in_range = (32'(xi) < X_CELLS) && (32'(yi) < Y_CELLS);
        px       = 10'(ORIGIN_X + 32'(xi) * CELL_SIZE);
        py       = 9'(ORIGIN_Y + 32'(yi) * CELL_SIZE);
    end

    // Request FSM next state, try counter and coordinate registers.
    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        rand_x_d  = rand_x_q;
        rand_y_d  = rand_y_q;
        tries_inc = tries_q + 8'd1;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StDraw;
                    tries_d = 8'd0;
                end
            end
            StDraw: begin
                tries_d = tries_inc;
                if (in_range) begin
                    state_d  = StCheck;
                    cand_x_d = px;
                    cand_y_d = py;
                end else if (tries_inc == MaxTries) begin
                    state_d = StFail;
                end else begin
                    state_d = StDraw;
                end
            end
            StCheck: begin
                if (!blocked) begin
                    state_d  = StDone;
                    rand_x_d = cand_x_q;
                    rand_y_d = cand_y_q;
                end else if (tries_q == MaxTries) begin
                    state_d = StFail;
                end else begin
                    state_d = StDraw;
                end
            end
            StDone:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM and coordinate state.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tries_q  <= 8'd0;
            cand_x_q <= 10'd0;
            cand_y_q <= 9'd0;
            rand_x_q <= 10'd0;
            rand_y_q <= 9'd0;
        end else begin
            state_q  <= state_d;
            tries_q  <= tries_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            rand_x_q <= rand_x_d;
            rand_y_q <= rand_y_d;
        end
    end

    // Outputs decoded from state so pulses line up with the updated coordinates.
    always_comb begin
        cand_x = cand_x_q;
        cand_y = cand_y_q;
        rand_x = rand_x_q;
        rand_y = rand_y_q;
        valid  = (state_q == StDone);
        fail   = (state_q == StFail);
        busy   = (state_q != StIdle);
    end

endmodule

// File: tb/tb_food_position_generator.sv
// Self-checking bench for food_position_generator.
// A transaction-level model plans the whole cycle timeline of each accepted
// request from the LFSR sequence and the bench's own blocking policy; a compare
// process checks every cycle against it. A second instance with MAX_TRIES=4 and
// blocked tied high covers the give-up path.
module tb_food_position_generator;

    localparam int X    = 62;
    localparam int Y    = 46;
    localparam int CS   = 10;
    localparam int OX   = 10;
    localparam int OY   = 10;
    localparam int MAXT = 16;
    localparam int XMOD = 64;
    localparam int YMOD = 64;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic       busy;
        logic       valid;
        logic       fail;
        logic       chk;
        logic       blk;
        logic [9:0] cx;
        logic [8:0] cy;
        logic [9:0] rx;
        logic [8:0] ry;
    } rec_t;

    logic VGA_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic req     = 1'b0;
    logic req2    = 1'b0;
    logic blocked;
    logic        seed_ld = 1'b0;
    logic [15:0] seed    = 16'h0000;

    logic [9:0] cand_x, rand_x, cand_x2, rand_x2;
    logic [8:0] cand_y, rand_y, cand_y2, rand_y2;
    logic valid, fail, busy, valid2, fail2, busy2;

    int n_tests = 0;
    int n_fail  = 0;
    int v_cnt, f_cnt;
    logic [9:0] last_rx;
    logic [8:0] last_ry;

    // Model state
    rec_t        cur = '0;
    rec_t        m_nx;
    rec_t        q[$];
    logic [15:0] m_lfsr = SEED;
    logic [9:0]  m_cx = '0, m_rx = '0;
    logic [8:0]  m_cy = '0, m_ry = '0;
    int          blk_first = 0;
    bit          blk_all = 1'b0;

    assign blocked = cur.blk;

    always #5 VGA_clk = ~VGA_clk;

    food_position_generator dut (
        .VGA_clk (VGA_clk),
        .rst_n   (rst_n),
        .req     (req),
        .blocked (blocked),
`ifdef FOOD_GEN_SEED_LOAD_EN
        .seed_ld (seed_ld),
        .seed    (seed),
`endif
        .cand_x  (cand_x),
        .cand_y  (cand_y),
        .rand_x  (rand_x),
        .rand_y  (rand_y),
        .valid   (valid),
        .fail    (fail),
        .busy    (busy)
    );

    food_position_generator #(.MAX_TRIES(4)) dut2 (
        .VGA_clk (VGA_clk),
        .rst_n   (rst_n),
        .req     (req2),
        .blocked (1'b1),
`ifdef FOOD_GEN_SEED_LOAD_EN
        .seed_ld (1'b0),
        .seed    (16'h0000),
`endif
        .cand_x  (cand_x2),
        .cand_y  (cand_y2),
        .rand_x  (rand_x2),
        .rand_y  (rand_y2),
        .valid   (valid2),
        .fail    (fail2),
        .busy    (busy2)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'h0000) return 16'h0001;
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lay out every cycle of one request, from its first draw to DONE/FAIL.
    task automatic plan_request(input logic [15:0] l_now);
        logic [15:0] l;
        int tries, nchk, xi, yi;
        bit b, done;
        rec_t r;
        l = lfsr_step(l_now);
        tries = 0;
        nchk = 0;
        done = 0;
        while (!done) begin
            tries++;
            xi = int'(l) % XMOD;
            yi = (int'(l) / XMOD) % YMOD;
            r = '0;
            r.busy = 1'b1;
            r.cx = m_cx; r.cy = m_cy; r.rx = m_rx; r.ry = m_ry;
            q.push_back(r);
            if (xi < X && yi < Y) begin
                m_cx = 10'(OX + xi * CS);
                m_cy = 9'(OY + yi * CS);
                b = blk_all || (nchk < blk_first);
                nchk++;
                r.cx = m_cx; r.cy = m_cy; r.chk = 1'b1; r.blk = b;
                q.push_back(r);
                l = lfsr_step(lfsr_step(l));
                if (!b) begin
                    m_rx = m_cx; m_ry = m_cy;
                    r.chk = 1'b0; r.blk = 1'b0; r.valid = 1'b1;
                    r.rx = m_rx; r.ry = m_ry;
                    q.push_back(r);
                    done = 1;
                end
            end else begin
                l = lfsr_step(l);
            end
            if (!done && tries == MAXT) begin
                r = '0;
                r.busy = 1'b1; r.fail = 1'b1;
                r.cx = m_cx; r.cy = m_cy; r.rx = m_rx; r.ry = m_ry;
                q.push_back(r);
                done = 1;
            end
        end
    endtask

    // Model: accept requests only when idle, then replay the planned timeline.
    always @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_lfsr = SEED;
            m_cx = '0; m_cy = '0; m_rx = '0; m_ry = '0;
            cur <= '0;
        end else begin
            if (!cur.busy && req) plan_request(m_lfsr);
            if (q.size() > 0) begin
                m_nx = q.pop_front();
            end else begin
                m_nx = '0;
                m_nx.cx = m_cx; m_nx.cy = m_cy; m_nx.rx = m_rx; m_nx.ry = m_ry;
            end
            cur <= m_nx;
`ifdef FOOD_GEN_SEED_LOAD_EN
            if (seed_ld) m_lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
            else m_lfsr = lfsr_step(m_lfsr);
`else
            m_lfsr = lfsr_step(m_lfsr);
`endif
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge VGA_clk) begin
        n_tests++;
        if ({busy, valid, fail, cand_x, cand_y, rand_x, rand_y} !==
            {cur.busy, cur.valid, cur.fail, cur.cx, cur.cy, cur.rx, cur.ry}) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t got b/v/f=%b%b%b cand=(%0d,%0d) rand=(%0d,%0d) exp b/v/f=%b%b%b cand=(%0d,%0d) rand=(%0d,%0d)",
                     $time, busy, valid, fail, cand_x, cand_y, rand_x, rand_y,
                     cur.busy, cur.valid, cur.fail, cur.cx, cur.cy, cur.rx, cur.ry);
        end
        if (valid && fail) begin
            n_fail++;
            $display("FAIL valid_and_fail: got both high, required exclusive at %0t", $time);
        end
    end

    task automatic clr_cnt();
        v_cnt = 0;
        f_cnt = 0;
    endtask

    task automatic tick();
        @(negedge VGA_clk);
        if (valid) begin
            v_cnt++;
            last_rx = rand_x;
            last_ry = rand_y;
            chk("rx_range", 32'(rand_x >= 10 && rand_x <= 620 && (rand_x - 10) % 10 == 0), 32'd1);
            chk("ry_range", 32'(rand_y >= 10 && rand_y <= 460 && (rand_y - 10) % 10 == 0), 32'd1);
        end
        if (fail) f_cnt++;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

`ifdef FOOD_GEN_SEED_LOAD_EN
    logic [18:0] seq_a[3];
    logic [18:0] seq_b[3];

    task automatic seeded_run(input logic [15:0] s, output logic [18:0] res[3]);
        seed = s;
        seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clr_cnt();
            pulse_req();
            repeat (40) tick();
            res[k] = {last_rx, last_ry};
            chk("seed_run_valid", 32'(v_cnt), 32'd1);
        end
    endtask
`endif

    initial begin
        bit found;
        int fail_k;
        int v2, f2;

        // Reset state
        repeat (2) @(negedge VGA_clk);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rand", 32'({rand_x, rand_y}), 32'd0);

        // First request from reset: draw uses 16'h59C3 -> cell (3,39) -> (40,400)
        rst_n = 1'b1;
        req = 1'b1;
        @(negedge VGA_clk);
        req = 1'b0;
        chk("lfsr_step1", 32'(dut.lfsr_q), 32'h000059C3);
        chk("busy_draw", 32'(busy), 32'd1);
        @(negedge VGA_clk);
        chk("valid_n2", 32'(valid), 32'd0);
        @(negedge VGA_clk);
        chk("valid_n3", 32'(valid), 32'd1);
        chk("first_rx", 32'(rand_x), 32'd40);
        chk("first_ry", 32'(rand_y), 32'd400);
        repeat (5) tick();

        // First two checks blocked, third accepted
        blk_first = 2;
        clr_cnt();
        pulse_req();
        repeat (40) tick();
        chk("blk2_valid", 32'(v_cnt), 32'd1);
        chk("blk2_fail", 32'(f_cnt), 32'd0);
        blk_first = 0;

        // Request pulsed again while busy is ignored
        clr_cnt();
        pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (40) tick();
        chk("busy_req_ignored", 32'(v_cnt), 32'd1);

        // Always blocked: gives up after MAX_TRIES
        blk_all = 1'b1;
        clr_cnt();
        pulse_req();
        repeat (40) tick();
        chk("allblk_fail", 32'(f_cnt), 32'd1);
        chk("allblk_valid", 32'(v_cnt), 32'd0);
        blk_all = 1'b0;

        // MAX_TRIES=4 instance, blocked tied high
        v2 = 0; f2 = 0; fail_k = 0;
        req2 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge VGA_clk);
            req2 = 1'b0;
            if (valid2) v2++;
            if (fail2) begin
                f2++;
                if (fail_k == 0) fail_k = k;
            end
        end
        chk("max4_fail_cnt", 32'(f2), 32'd1);
        chk("max4_valid_cnt", 32'(v2), 32'd0);
        chk("max4_fail_by_n10", 32'(fail_k >= 1 && fail_k <= 10), 32'd1);
        chk("max4_rand_kept", 32'({rand_x2, rand_y2}), 32'd0);

        // req held high: back-to-back requests
        blk_first = 1;
        clr_cnt();
        req = 1'b1;
        repeat (1000) tick();
        req = 1'b0;
        repeat (40) tick();
        chk("held_progress", 32'(v_cnt + f_cnt >= 20), 32'd1);
        blk_first = 0;

        // Reset mid-CHECK
        clr_cnt();
        pulse_req();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (cur.chk) found = 1;
            else tick();
        end
        chk("reach_check", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_vf", 32'({valid, fail}), 32'd0);
        chk("midrst_cand", 32'({cand_x, cand_y}), 32'd0);
        chk("midrst_rand", 32'({rand_x, rand_y}), 32'd0);
        chk("midrst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        repeat (2) @(negedge VGA_clk);
        rst_n = 1'b1;
        clr_cnt();
        repeat (10) tick();
        chk("post_rst_no_pulse", 32'(v_cnt + f_cnt), 32'd0);

`ifdef FOOD_GEN_SEED_LOAD_EN
        // Zero seed is replaced by 1, then the LFSR advances to 2
        seed = 16'h0000;
        seed_ld = 1'b1;
        @(negedge VGA_clk);
        seed_ld = 1'b0;
        chk("seed0_load", 32'(dut.lfsr_q), 32'h00000001);
        @(negedge VGA_clk);
        chk("seed0_next", 32'(dut.lfsr_q), 32'h00000002);
        seeded_run(16'h1234, seq_a);
        seeded_run(16'h1234, seq_b);
        for (int k = 0; k < 3; k++) chk("seed_repeat", 32'(seq_b[k]), 32'(seq_a[k]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
